// File: rtl/seq_detector_prog.sv
// Serial pattern detector: runtime-loadable N-bit pattern, overlap/non-overlap
// matching, input qualifier and a saturating match counter. Outputs are registered.
module seq_detector_prog #(
  parameter int             N             = 4,
  parameter int             CNT_W         = 8,
  parameter logic [N-1:0]   RESET_PATTERN = N'(4'b1010),
  parameter bit             RESET_OVERLAP = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in,
  input  logic             cfg_load,
  input  logic [N-1:0]     cfg_pattern,
  input  logic             cfg_overlap,
  input  logic             clear,
  output logic             detect,
  output logic [CNT_W-1:0] match_count
);

  localparam int FW = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_FULL = FW'(N);

  logic [N-1:0]  pat_q;
  logic          ovl_q;
  logic [N-1:0]  hist;
  logic [FW-1:0] fill;

  logic [N-1:0]  hist_nxt;
  logic [FW-1:0] fill_nxt;
  logic          hit;

  // Match is judged on the post-shift history so detect lands one cycle after the last bit.
  always_comb begin
    hist_nxt = {hist[N-2:0], in};
    fill_nxt = (fill == FILL_FULL) ? FILL_FULL : fill + FW'(1);
    hit      = (fill_nxt == FILL_FULL) && (hist_nxt == pat_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q       <= RESET_PATTERN;
      ovl_q       <= RESET_OVERLAP;
      hist        <= '0;
      fill        <= '0;
      detect      <= 1'b0;
      match_count <= '0;
    end else begin
      detect <= 1'b0;
      if (cfg_load || clear) begin
        // Control cycles drop any bit presented alongside them.
        hist <= '0;
        fill <= '0;
        if (cfg_load) begin
          pat_q <= cfg_pattern;
          ovl_q <= cfg_overlap;
        end
        if (clear) match_count <= '0;
      end else if (in_valid) begin
        hist <= hist_nxt;
        if (hit) begin
          detect <= 1'b1;
          if (match_count != '1) match_count <= match_count + CNT_W'(1);
          // Non-overlap restarts the fill so the next match needs N fresh bits.
          fill <= ovl_q ? fill_nxt : '0;
        end else begin
          fill <= fill_nxt;
        end
      end
    end
  end

endmodule
